wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline write-back stage and a long-latency result source (multiply/divide unit), buffering long-latency results in a small FIFO until a free write slot appears. It sits between the write-back stage and the register file. It drops stale buffered results overwritten by younger pipeline writes (WAW). It exposes busy flags so decode can detect RAW hazards on buffered results.

---
 rtl/wb_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between the in-order write-back stage
// and a long-latency result source. Long-latency results wait in a small FIFO
// until a cycle with no active pipeline write. Younger pipeline writes kill
// buffered entries with the same destination (WAW), and busy flags let decode
// see RAW hazards on buffered results.
// Optional feature macro: WBARB_STARVE_GUARD_EN enables the starvation counter
// and stall_req. When it is undefined, stall_req is tied low.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_we,
  input  logic [4:0]                 wb_rd,
  input  logic [31:0]                wb_wdata,
  input  logic                       ll_valid,
  output logic                       ll_ready,
  input  logic [4:0]                 ll_rd,
  input  logic [31:0]                ll_wdata,
  input  logic [4:0]                 q_rs1,
  input  logic [4:0]                 q_rs2,
  output logic                       q_rs1_busy,
  output logic                       q_rs2_busy,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic                       stall_req,
  output logic [$clog2(DEPTH):0]     pend_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // FIFO storage: one live bit, destination and data per slot
  logic          live_r [DEPTH];
  logic [4:0]    rd_r   [DEPTH];
  logic [31:0]   data_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;

  logic wb_active_s;
  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic head_live_s;
  logic push_live_s;

  // An x0 destination never counts as a write; the pipeline always has priority
  assign wb_active_s = wb_we && (wb_rd != 5'd0);
  assign full_s      = (cnt_r == FULL_CNT);
  assign empty_s     = (cnt_r == {CW{1'b0}});
  // Readiness looks only at stored occupancy, never at a same-cycle pop
  assign push_s      = ll_valid && !full_s;
  assign pop_s       = !wb_active_s && !empty_s;
  assign head_live_s = live_r[rd_ptr_r];
  // A push to x0, or to the register the pipeline writes this cycle, is stored dead
  assign push_live_s = (ll_rd != 5'd0) && !(wb_active_s && (ll_rd == wb_rd));

  assign ll_ready = !full_s;
  assign pend_cnt = cnt_r;

  // RAW query: a live stored entry targeting a nonzero source register
  always_comb begin
    q_rs1_busy = 1'b0;
    q_rs2_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_r[i] && (rd_r[i] == q_rs1) && (q_rs1 != 5'd0)) begin
        q_rs1_busy = 1'b1;
      end else begin
        q_rs1_busy = q_rs1_busy;
      end
      if (live_r[i] && (rd_r[i] == q_rs2) && (q_rs2 != 5'd0)) begin
        q_rs2_busy = 1'b1;
      end else begin
        q_rs2_busy = q_rs2_busy;
      end
    end
  end

  // FIFO state: WAW kill, pop of the head, push at the tail, occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_r[i] <= 1'b0;
        rd_r[i]   <= 5'd0;
        data_r[i] <= 32'd0;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_active_s && (rd_r[i] == wb_rd)) begin
          live_r[i] <= 1'b0;
        end
      end
      // Popped slots are cleared so stale entries never report busy
      if (pop_s) begin
        live_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r         <= rd_ptr_r + PW'(1);
      end
      // Push last so the tail slot ignores any kill aimed at its stale content
      if (push_s) begin
        live_r[wr_ptr_r] <= push_live_s;
        rd_r[wr_ptr_r]   <= ll_rd;
        data_r[wr_ptr_r] <= ll_wdata;
        wr_ptr_r         <= wr_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Registered write port: pipeline first, then a live FIFO head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (wb_active_s) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_rd;
      rf_wdata <= wb_wdata;
    end else if (pop_s && head_live_s) begin
      rf_we    <= 1'b1;
      rf_waddr <= rd_r[rd_ptr_r];
      rf_wdata <= data_r[rd_ptr_r];
    end else begin
      rf_we    <= 1'b0;
      rf_waddr <= rf_waddr;
      rf_wdata <= rf_wdata;
    end
  end

`ifdef WBARB_STARVE_GUARD_EN
  logic [7:0] starve_r;
  logic       stall_req_r;
  logic       blocked_s;
  logic       head_kill_s;

  assign blocked_s   = wb_active_s && !empty_s && head_live_s;
  assign head_kill_s = blocked_s && (rd_r[rd_ptr_r] == wb_rd);

  // Count cycles a live head loses the port; any pop or head kill restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_r <= 8'd0;
    end else if (head_kill_s || pop_s) begin
      starve_r <= 8'd0;
    end else if (blocked_s && (starve_r != 8'hFF)) begin
      starve_r <= starve_r + 8'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Stall request reflects the counter as it stood before this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_req_r <= 1'b0;
    end else begin
      stall_req_r <= (starve_r >= 8'(STARVE_LIMIT));
    end
  end

  assign stall_req = stall_req_r;
`else
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter. Expected register-file writes are
// queued when stimulus is driven and compared as the DUT produces them.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CW           = $clog2(DEPTH) + 1;

`ifdef WBARB_STARVE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_wdata;
  logic          ll_valid;
  logic          ll_ready;
  logic [4:0]    ll_rd;
  logic [31:0]   ll_wdata;
  logic [4:0]    q_rs1;
  logic [4:0]    q_rs2;
  logic          q_rs1_busy;
  logic          q_rs2_busy;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          stall_req;
  logic [CW-1:0] pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q [$];

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_wdata(ll_wdata),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rs1_busy(q_rs1_busy), .q_rs2_busy(q_rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge, then pop and compare any register-file write
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (rf_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write_unexpected: got addr=%0d data=%h, expected no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          n_fail++;
          $display("FAIL rf_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_rd = 5'd0; wb_wdata = 32'd0;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_wdata = 32'd0;
    q_rs1 = 5'd0; q_rs2 = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b, expected 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d, expected 0", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h, expected 0", rf_wdata); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, expected 0", stall_req); end
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_pend: got %0d, expected 0", pend_cnt); end
    n_checks++; if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ll_ready: got %b, expected 1", ll_ready); end
    n_checks++; if ({q_rs1_busy, q_rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b, expected 00", {q_rs1_busy, q_rs2_busy}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ll_valid = 1'b1; ll_rd = 5'd5; ll_wdata = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    ll_valid = 1'b0; q_rs1 = 5'd5;
    #1;
    n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL basic_pend1: got %0d, expected 1", pend_cnt); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_write: got %b, expected 0", rf_we); end
    n_checks++; if (q_rs1_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, expected 1", q_rs1_busy); end
    tick();
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL basic_write: got %b, expected 1", rf_we); end
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL basic_pend0: got %0d, expected 0", pend_cnt); end
    n_checks++; if (q_rs1_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_clear: got %b, expected 0", q_rs1_busy); end
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL basic_we_drop: got %b, expected 0", rf_we); end
    q_rs1 = 5'd0;
  endtask

  task automatic test_starve();
    wb_we = 1'b1; wb_rd = 5'd3;
    for (int c = 0; c < 8; c++) begin
      wb_wdata = 32'h3000_0000 + 32'(c);
      exp_q.push_back({5'd3, wb_wdata});
      ll_valid = (c == 0); ll_rd = 5'd7; ll_wdata = 32'h7777_0007;
      tick();
      if (c == 2) begin
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_early: got %b, expected 0", stall_req); end
      end
    end
    ll_valid = 1'b0;
    n_checks++; if (stall_req !== GUARD) begin n_fail++; $display("FAIL starve_stall: got %b, expected %b", stall_req, GUARD); end
    n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL starve_pend: got %0d, expected 1", pend_cnt); end
    wb_we = 1'b0;
    exp_q.push_back({5'd7, 32'h7777_0007});
    tick();
    n_checks++; if (stall_req !== GUARD) begin n_fail++; $display("FAIL starve_stall_hold: got %b, expected %b", stall_req, GUARD); end
    tick();
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_stall_fall: got %b, expected 0", stall_req); end
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL starve_pend0: got %0d, expected 0", pend_cnt); end
  endtask

  task automatic test_kill();
    wb_we = 1'b1; wb_rd = 5'd2; wb_wdata = 32'h22;
    exp_q.push_back({5'd2, 32'h22});
    ll_valid = 1'b1; ll_rd = 5'd9; ll_wdata = 32'h99;
    tick();
    ll_valid = 1'b0; q_rs1 = 5'd9;
    #1;
    n_checks++; if (q_rs1_busy !== 1'b1) begin n_fail++; $display("FAIL kill_busy_before: got %b, expected 1", q_rs1_busy); end
    wb_rd = 5'd9; wb_wdata = 32'h9;
    exp_q.push_back({5'd9, 32'h9});
    tick();
    wb_we = 1'b0;
    #1;
    n_checks++; if (q_rs1_busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy_after: got %b, expected 0", q_rs1_busy); end
    n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL kill_pend: got %0d, expected 1", pend_cnt); end
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL kill_dead_drain: got %b, expected 0", rf_we); end
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL kill_pend0: got %0d, expected 0", pend_cnt); end
    // Same-cycle push and kill of the same register
    wb_we = 1'b1; wb_rd = 5'd11; wb_wdata = 32'hB;
    exp_q.push_back({5'd11, 32'hB});
    ll_valid = 1'b1; ll_rd = 5'd11; ll_wdata = 32'hBB; q_rs2 = 5'd11;
    tick();
    ll_valid = 1'b0; wb_we = 1'b0;
    #1;
    n_checks++; if (q_rs2_busy !== 1'b0) begin n_fail++; $display("FAIL kill_push_busy: got %b, expected 0", q_rs2_busy); end
    n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL kill_push_pend: got %0d, expected 1", pend_cnt); end
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL kill_push_drain: got %b, expected 0", rf_we); end
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL kill_push_pend0: got %0d, expected 0", pend_cnt); end
    q_rs1 = 5'd0; q_rs2 = 5'd0;
  endtask

  task automatic test_full();
    wb_we = 1'b1; wb_rd = 5'd4; wb_wdata = 32'h40;
    exp_q.push_back({5'd4, 32'h40});
    ll_valid = 1'b1; ll_rd = 5'd12; ll_wdata = 32'hC;
    tick();
    n_checks++; if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_one: got %b, expected 1", ll_ready); end
    wb_wdata = 32'h41; exp_q.push_back({5'd4, 32'h41});
    ll_rd = 5'd13; ll_wdata = 32'hD;
    tick();
    n_checks++; if (ll_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready0: got %b, expected 0", ll_ready); end
    n_checks++; if (pend_cnt !== 2'd2) begin n_fail++; $display("FAIL full_pend2: got %0d, expected 2", pend_cnt); end
    wb_wdata = 32'h42; exp_q.push_back({5'd4, 32'h42});
    ll_rd = 5'd14; ll_wdata = 32'hE;
    tick();
    n_checks++; if (pend_cnt !== 2'd2) begin n_fail++; $display("FAIL full_ignore: got %0d, expected 2", pend_cnt); end
    wb_we = 1'b0;
    exp_q.push_back({5'd12, 32'hC});
    tick();
    n_checks++; if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b, expected 1", ll_ready); end
    n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL full_pend_free: got %0d, expected 1", pend_cnt); end
    exp_q.push_back({5'd13, 32'hD});
    tick();
    ll_valid = 1'b0;
    n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL full_push_pop: got %0d, expected 1", pend_cnt); end
    exp_q.push_back({5'd14, 32'hE});
    tick();
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL full_pend0: got %0d, expected 0", pend_cnt); end
  endtask

  task automatic test_x0();
    wb_we = 1'b1; wb_rd = 5'd6; wb_wdata = 32'h66;
    exp_q.push_back({5'd6, 32'h66});
    ll_valid = 1'b1; ll_rd = 5'd20; ll_wdata = 32'h2020;
    tick();
    ll_valid = 1'b0; wb_rd = 5'd0; wb_wdata = 32'hBAD;
    exp_q.push_back({5'd20, 32'h2020});
    tick();
    n_checks++; if (rf_waddr !== 5'd20) begin n_fail++; $display("FAIL x0_drain_addr: got %0d, expected 20", rf_waddr); end
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL x0_drain_pend: got %0d, expected 0", pend_cnt); end
    wb_we = 1'b0; ll_valid = 1'b1; ll_rd = 5'd0; ll_wdata = 32'h0BAD;
    tick();
    ll_valid = 1'b0;
    n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL x0_push_pend: got %0d, expected 1", pend_cnt); end
    n_checks++; if (q_rs2_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %b, expected 0", q_rs2_busy); end
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_never_written: got %b, expected 0", rf_we); end
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL x0_pend0: got %0d, expected 0", pend_cnt); end
  endtask

  task automatic test_reset_mid();
    wb_we = 1'b1; wb_rd = 5'd8; wb_wdata = 32'h88;
    exp_q.push_back({5'd8, 32'h88});
    ll_valid = 1'b1; ll_rd = 5'd21; ll_wdata = 32'h21;
    tick();
    wb_wdata = 32'h89; exp_q.push_back({5'd8, 32'h89});
    ll_rd = 5'd22; ll_wdata = 32'h22;
    tick();
    ll_valid = 1'b0; wb_we = 1'b0; q_rs1 = 5'd21;
    n_checks++; if (pend_cnt !== 2'd2) begin n_fail++; $display("FAIL rstmid_pend2: got %0d, expected 2", pend_cnt); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_rf_we: got %b, expected 0", rf_we); end
    n_checks++; if ({rf_waddr, rf_wdata} !== 37'd0) begin n_fail++; $display("FAIL rstmid_rf_bus: got %h, expected 0", {rf_waddr, rf_wdata}); end
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL rstmid_pend: got %0d, expected 0", pend_cnt); end
    n_checks++; if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b, expected 1", ll_ready); end
    n_checks++; if (q_rs1_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, expected 0", q_rs1_busy); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b, expected 0", stall_req); end
    tick();
    rst = 1'b0;
    repeat (4) tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_write: got %b, expected 0", rf_we); end
    n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL rstmid_pend_after: got %0d, expected 0", pend_cnt); end
    q_rs1 = 5'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starve();
    test_kill();
    test_full();
    test_x0();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: got %0d pending writes, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
